// File: rtl/jk_counter_reg_if.sv
// Control/state bus for jk_counter_reg: mode and per-bit JK/load inputs, plus register state,
// terminal count and wrap pulse. master drives the controls; slave is the register.
interface jk_counter_reg_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, j, k, d,
    input  q, tc, wrap
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, tc, wrap
  );
endinterface

// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK-cell register, reusable as up/down modulo counter or parallel load; 1-cycle latency to q/wrap.
// No backpressure: en=0 freezes q and clears wrap; tc is combinational from q and mode.
module jk_counter_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter bit               SATURATE  = 1'b0
) (
  input logic              clk,
  input logic              reset,
  jk_counter_reg_if.slave  bus
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] up_tgl;
  logic [WIDTH-1:0] dn_tgl;
  logic             up_acc;
  logic             dn_acc;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_zero;

  // Ripple toggle-enable chains: a bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_acc = 1'b1;
    dn_acc = 1'b1;
    up_tgl = '0;
    dn_tgl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_tgl[i] = up_acc;
      dn_tgl[i] = dn_acc;
      up_acc    = up_acc & q_r[i];
      dn_acc    = dn_acc & ~q_r[i];
    end
  end

  // Loaded values above MAX_COUNT count as terminal so the next up-count wraps.
  assign at_max  = (q_r >= MAX_COUNT);
  assign at_zero = (q_r == '0);

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    case (bus.mode)
      MODE_JK: q_nxt = (bus.j & ~q_r) | (~bus.k & q_r);
      MODE_UP: begin
        if (!at_max) begin
          q_nxt = q_r ^ up_tgl;
        end else if (SATURATE) begin
          q_nxt = MAX_COUNT;
        end else begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end
      MODE_DN: begin
        if (!at_zero) begin
          q_nxt = q_r ^ dn_tgl;
        end else if (SATURATE) begin
          q_nxt = '0;
        end else begin
          q_nxt    = MAX_COUNT;
          wrap_nxt = 1'b1;
        end
      end
      default: q_nxt = bus.d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= RESET_VAL;
      wrap_r <= 1'b0;
    end else begin
      if (bus.en) begin
        q_r <= q_nxt;
      end
      wrap_r <= bus.en & wrap_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
  assign bus.tc   = ((bus.mode == MODE_UP) && at_max) || ((bus.mode == MODE_DN) && at_zero);

endmodule
